// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes,
// FSM state encoding, default latencies and the cycle counter width.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    localparam int CNT_W = 16;

    // Ops 0-3 are the multi-cycle multiply/divide group (bit 2 clear).
    function automatic logic isMulDiv(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath. kind_i is the low two bits of a
// mul/div op: bit 1 selects divide, bit 0 selects unsigned arithmetic.
// Division is done on magnitudes and the signs are fixed up afterwards, so
// the 0x80000000 / -1 overflow case naturally yields lo=0x80000000, hi=0.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [1:0]  kind_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        divByZero_o
);

    logic        isDiv;
    logic        isUnsigned;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [63:0] product;
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisor;
    logic [31:0] quoU;
    logic [31:0] remU;
    logic [31:0] quo;
    logic [31:0] rem;

    // Compute both product and quotient/remainder, then select by kind.
    always_comb begin
        isDiv      = (kind_i == OP_DIV[1:0]) || (kind_i == OP_DIVU[1:0]);
        isUnsigned = (kind_i == OP_MULTU[1:0]) || (kind_i == OP_DIVU[1:0]);

        mulA    = isUnsigned ? {32'd0, a_i} : {{32{a_i[31]}}, a_i};
        mulB    = isUnsigned ? {32'd0, b_i} : {{32{b_i[31]}}, b_i};
        product = mulA * mulB;

        negA    = !isUnsigned && a_i[31];
        negB    = !isUnsigned && b_i[31];
        magA    = negA ? (32'd0 - a_i) : a_i;
        magB    = negB ? (32'd0 - b_i) : b_i;
        divisor = (b_i == 32'd0) ? 32'd1 : magB;
        quoU    = magA / divisor;
        remU    = magA % divisor;
        quo     = (negA ^ negB) ? (32'd0 - quoU) : quoU;
        rem     = negA ? (32'd0 - remU) : remU;

        hi_o        = isDiv ? rem : product[63:32];
        lo_o        = isDiv ? quo : product[31:0];
        divByZero_o = isDiv && (b_i == 32'd0);
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit top: accepts an op in IDLE, computes the result up
// front into pending registers, counts down a fixed latency while busy and
// then commits the pending value to HI/LO with a one-cycle done pulse.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    logic             state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      hi_q,        hi_d;
    logic [31:0]      lo_q,        lo_d;
    logic [31:0]      pendHi_q,    pendHi_d;
    logic [31:0]      pendLo_q,    pendLo_d;
    logic             pendWrite_q, pendWrite_d;
    logic             done_q,      done_d;

    logic [31:0] calcHi;
    logic [31:0] calcLo;
    logic        calcDivByZero;

    mdu_calc u_calc (
        .kind_i      (op_i[1:0]),
        .a_i         (src_a_i),
        .b_i         (src_b_i),
        .hi_o        (calcHi),
        .lo_o        (calcLo),
        .divByZero_o (calcDivByZero)
    );

    // Next-state logic: accept ops only in IDLE, count down while BUSY.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pendHi_d    = pendHi_q;
        pendLo_d    = pendLo_q;
        pendWrite_d = pendWrite_q;
        done_d      = 1'b0;

        if (state_q == S_IDLE) begin
            if (start_i) begin
                if (isMulDiv(op_i)) begin
                    state_d     = S_BUSY;
                    cnt_d       = op_i[1] ? DIV_CNT : MULT_CNT;
                    pendHi_d    = calcHi;
                    pendLo_d    = calcLo;
                    pendWrite_d = !calcDivByZero;
                end else if (op_i == OP_MTHI) begin
                    hi_d = src_a_i;
                end else if (op_i == OP_MTLO) begin
                    lo_d = src_a_i;
                end
            end
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (pendWrite_q) begin
                    hi_d = pendHi_q;
                    lo_d = pendLo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset; reset drops any
    // in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            pendHi_q    <= '0;
            pendLo_q    <= '0;
            pendWrite_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pendHi_q    <= pendHi_d;
            pendLo_q    <= pendLo_d;
            pendWrite_q <= pendWrite_d;
            done_q      <= done_d;
        end
    end

    assign busy_o = (state_q == S_BUSY);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a table of mul/div vectors with hand-computed
// HI/LO, plus hand-written sequences for MT ops, busy-time ignores,
// mid-operation reset and back-to-back issue.
module tb_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checkCount;
    int passCount;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[8];

    mdu #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (op),
        .src_a_i (srcA),
        .src_b_i (srcB),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Present one op with start for a single edge, then drop start.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        step();
        start = 1'b0;
        op    = 3'd7;
        srcA  = 32'hDEAD_BEEF;
        srcB  = 32'h0BAD_F00D;
    endtask

    // Called just after the accepting edge: expects n busy cycles, then the
    // done cycle with the given HI/LO. Leaves time inside the done cycle.
    task automatic waitAndCheck(input int n, input logic [31:0] expHi,
                                input logic [31:0] expLo, input string name);
        for (int i = 0; i < n; i++) begin
            checkOutput({name, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({name, " early done"}, {31'd0, done}, 32'd0);
            step();
        end
        checkOutput({name, " busy end"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " done"}, {31'd0, done}, 32'd1);
        checkOutput({name, " hi"}, hi, expHi);
        checkOutput({name, " lo"}, lo, expLo);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        srcA  = 32'd0;
        srcB  = 32'd0;

        vecs[0] = '{"MULT neg",     3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"MULTU max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"DIV -7/2",     3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"DIVU by zero", 3'd3, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{"DIVU 100/7",   3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[5] = '{"DIV 7/-2",     3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{"MULT 2^16*-2^16", 3'd0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{"MULTU 2^16*x", 3'd1, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000};

        step();
        step();
        rst_n = 1'b1;
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].op, vecs[v].a, vecs[v].b);
            waitAndCheck(vecs[v].op[1] ? DIV_N : MULT_N, vecs[v].expHi, vecs[v].expLo, vecs[v].name);
            step();
            checkOutput({vecs[v].name, " done pulse width"}, {31'd0, done}, 32'd0);
            checkOutput({vecs[v].name, " idle"}, {31'd0, busy}, 32'd0);
        end

        // MTHI while a DIV is in flight must be dropped.
        applyStimulus(3'd2, 32'h0000_0064, 32'h0000_0007);
        applyStimulus(3'd4, 32'h1234_5678, 32'h0);
        applyStimulus(3'd5, 32'h5555_5555, 32'h0);
        checkOutput("MT in busy hi", hi, 32'h0000_FFFF);
        waitAndCheck(DIV_N - 2, 32'h0000_0002, 32'h0000_000E, "DIV under MT");
        step();

        // MTHI / MTLO in IDLE write the next cycle without going busy.
        applyStimulus(3'd4, 32'h1234_5678, 32'h0);
        checkOutput("MTHI hi", hi, 32'h1234_5678);
        checkOutput("MTHI busy", {31'd0, busy}, 32'd0);
        checkOutput("MTHI done", {31'd0, done}, 32'd0);
        applyStimulus(3'd5, 32'hCAFE_BABE, 32'h0);
        checkOutput("MTLO lo", lo, 32'hCAFE_BABE);
        checkOutput("MTLO hi kept", hi, 32'h1234_5678);
        step();
        checkOutput("MT no done", {31'd0, done}, 32'd0);

        // Reserved ops leave everything alone.
        applyStimulus(3'd6, 32'h1111_1111, 32'h2);
        applyStimulus(3'd7, 32'h2222_2222, 32'h3);
        checkOutput("reserved hi", hi, 32'h1234_5678);
        checkOutput("reserved lo", lo, 32'hCAFE_BABE);
        checkOutput("reserved busy", {31'd0, busy}, 32'd0);

        // Reset on the third busy cycle of a MULT aborts it silently.
        applyStimulus(3'd0, 32'h0000_0003, 32'h0000_0004);
        step();
        step();
        checkOutput("pre-abort busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        for (int i = 0; i < MULT_N; i++) begin
            checkOutput("abort no done", {31'd0, done}, 32'd0);
            checkOutput("abort stays idle", {31'd0, busy}, 32'd0);
            step();
        end
        checkOutput("abort hi later", hi, 32'd0);

        // Overflow divide, then a new op issued in its done cycle.
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitAndCheck(DIV_N, 32'h0000_0000, 32'h8000_0000, "DIV overflow");
        applyStimulus(3'd1, 32'h0000_0002, 32'h0000_0003);
        waitAndCheck(MULT_N, 32'h0000_0000, 32'h0000_0006, "back-to-back MULTU");
        step();
        checkOutput("final done low", {31'd0, done}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
